// File: rtl/stream_arb_pkg.sv
// Shared types for the flushable round-robin stream arbiter.
package stream_arb_pkg;

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StStop  = 2'd1,
      StFlush = 2'd2,
      StDone  = 2'd3
   } flush_state_e;

   function automatic logic [1:0] full_count(input logic a_full, input logic b_full);
      return {1'b0, a_full} + {1'b0, b_full};
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_i, wrapping.
module rr_arb_pick #(
   parameter int unsigned NumIn = 4,
   parameter int unsigned IdxW  = $clog2(NumIn)
) (
   input  logic [IdxW-1:0]  rr_i,
   input  logic [NumIn-1:0] valid_i,
   output logic [IdxW-1:0]  grant_o,
   output logic             any_o
);

   logic [IdxW:0]   sum;
   logic [IdxW-1:0] pick;

   always_comb begin
      grant_o = '0;
      any_o   = |valid_i;
      sum     = '0;
      pick    = '0;
      // Scan farthest offset first so the requester closest to rr_i overwrites last.
      for (int off = int'(NumIn) - 1; off >= 0; off--) begin
         sum = {1'b0, rr_i} + (IdxW+1)'(off);
         if (sum >= (IdxW+1)'(NumIn)) begin
            sum = sum - (IdxW+1)'(NumIn);
         end
         pick = sum[IdxW-1:0];
         if (valid_i[pick]) begin
            grant_o = pick;
         end
      end
   end

endmodule

// File: rtl/stream_arbiter_flushable.sv
// Round-robin N:1 stream arbiter with a two-entry spill buffer and a
// four-state flush sequence that discards buffered entries.
module stream_arbiter_flushable
   import stream_arb_pkg::*;
#(
   parameter int unsigned NumIn = 4,
   parameter type         T     = logic [31:0],
   parameter int unsigned IdxW  = $clog2(NumIn)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NumIn-1:0] inp_valid_i,
   output logic [NumIn-1:0] inp_ready_o,
   input  T                 inp_data_i [NumIn],
   output logic             oup_valid_o,
   input  logic             oup_ready_i,
   output T                 oup_data_o,
   output logic [IdxW-1:0]  oup_idx_o,
   input  logic             flush_req_i,
   output logic             flush_busy_o,
   output logic             flush_done_o,
   output logic [1:0]       flush_drop_o
);

   flush_state_e    state_q, state_d;
   logic [IdxW-1:0] rr_q, rr_d;
   logic            a_full_q, a_full_d, b_full_q, b_full_d;
   T                a_data_q, a_data_d, b_data_q, b_data_d;
   logic [IdxW-1:0] a_idx_q, a_idx_d, b_idx_q, b_idx_d;
   logic [1:0]      drop_q, drop_d;

   logic [IdxW-1:0] grant;
   logic            any_valid;
   logic            accept, in_hs, out_rdy;
   logic            a_fill, a_drain, b_fill, b_drain;

   rr_arb_pick #(
      .NumIn (NumIn),
      .IdxW  (IdxW)
   ) u_pick (
      .rr_i    (rr_q),
      .valid_i (inp_valid_i),
      .grant_o (grant),
      .any_o   (any_valid)
   );

   // Acceptance uses registered fullness only, so oup_ready_i never reaches inp_ready_o.
   assign accept  = !(a_full_q && b_full_q);
   assign in_hs   = (state_q == StRun) && !flush_req_i && accept && any_valid && !rst_i;
   assign out_rdy = oup_ready_i && (state_q != StFlush);

   assign a_fill  = in_hs;
   assign a_drain = a_full_q && !b_full_q;
   assign b_fill  = a_drain && !out_rdy;
   assign b_drain = b_full_q && out_rdy;

   always_comb begin
      inp_ready_o = '0;
      if (in_hs) begin
         inp_ready_o[grant] = 1'b1;
      end
      oup_valid_o  = (a_full_q || b_full_q) && (state_q != StFlush) && !rst_i;
      oup_data_o   = b_full_q ? b_data_q : a_data_q;
      oup_idx_o    = b_full_q ? b_idx_q : a_idx_q;
      flush_busy_o = (state_q != StRun) && !rst_i;
      flush_done_o = (state_q == StDone) && !rst_i;
      flush_drop_o = drop_q;
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      a_full_d = a_full_q;
      b_full_d = b_full_q;
      a_data_d = a_data_q;
      a_idx_d  = a_idx_q;
      b_data_d = b_data_q;
      b_idx_d  = b_idx_q;
      drop_d   = drop_q;

      if (a_fill || a_drain) begin
         a_full_d = a_fill;
      end
      if (a_fill) begin
         a_data_d = inp_data_i[grant];
         a_idx_d  = grant;
      end
      if (b_fill || b_drain) begin
         b_full_d = b_fill;
      end
      if (b_fill) begin
         b_data_d = a_data_q;
         b_idx_d  = a_idx_q;
      end
      if (in_hs) begin
         rr_d = (grant == IdxW'(NumIn - 1)) ? '0 : grant + IdxW'(1);
      end

      unique case (state_q)
         StRun:   if (flush_req_i) state_d = StStop;
         StStop:  state_d = StFlush;
         StFlush: begin
            state_d  = StDone;
            drop_d   = full_count(a_full_q, b_full_q);
            rr_d     = '0;
            a_full_d = 1'b0;
            b_full_d = 1'b0;
            a_data_d = '0;
            a_idx_d  = '0;
            b_data_d = '0;
            b_idx_d  = '0;
         end
         StDone:  state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StRun;
         rr_q     <= '0;
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_data_q <= '0;
         a_idx_q  <= '0;
         b_data_q <= '0;
         b_idx_q  <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         a_full_q <= a_full_d;
         b_full_q <= b_full_d;
         a_data_q <= a_data_d;
         a_idx_q  <= a_idx_d;
         b_data_q <= b_data_d;
         b_idx_q  <= b_idx_d;
         drop_q   <= drop_d;
      end
   end

endmodule

// File: tb/tb_stream_arbiter_flushable.sv
// Randomized bench: an occupancy/queue reference model predicts handshakes and flush
// status; a monitor pops expected payloads whenever the DUT completes an output handshake.
module tb_stream_arbiter_flushable;

   localparam int NumIn = 4;
   localparam int Cycles = 3000;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [NumIn-1:0] inp_valid_i;
   logic [NumIn-1:0] inp_ready_o;
   logic [31:0]      inp_data_i [NumIn];
   logic             oup_valid_o;
   logic             oup_ready_i;
   logic [31:0]      oup_data_o;
   logic [1:0]       oup_idx_o;
   logic             flush_req_i;
   logic             flush_busy_o;
   logic             flush_done_o;
   logic [1:0]       flush_drop_o;

   int checks = 0;
   int errors = 0;

   // Expected output stream: {idx, data}, oldest first.
   logic [33:0] exp_q [$];

   // Reference model: 0=run, 1=stop, 2=flush, 3=done.
   int phase, rr, occ, drop;

   stream_arbiter_flushable #(
      .NumIn (NumIn),
      .T     (logic [31:0])
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .inp_valid_i  (inp_valid_i),
      .inp_ready_o  (inp_ready_o),
      .inp_data_i   (inp_data_i),
      .oup_valid_o  (oup_valid_o),
      .oup_ready_i  (oup_ready_i),
      .oup_data_o   (oup_data_o),
      .oup_idx_o    (oup_idx_o),
      .flush_req_i  (flush_req_i),
      .flush_busy_o (flush_busy_o),
      .flush_done_o (flush_done_o),
      .flush_drop_o (flush_drop_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples after stimulus has settled, well away from the rising edge.
   initial begin
      logic [33:0] item;
      forever begin
         @(negedge clk_i);
         #2;
         if (oup_valid_o && oup_ready_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0h expected none", {oup_idx_o, oup_data_o});
            end else begin
               item = exp_q.pop_front();
               check("oup_payload", {30'd0, oup_idx_o, oup_data_o}, {30'd0, item});
            end
         end
      end
   end

   initial begin
      logic [NumIn-1:0] exp_ready;
      logic             exp_valid, in_hs, out_hs;
      int               g;
      bit               found, forced_rst_done;

      rst_i       = 1'b1;
      inp_valid_i = '0;
      oup_ready_i = 1'b0;
      flush_req_i = 1'b0;
      for (int i = 0; i < NumIn; i++) inp_data_i[i] = '0;
      phase = 0; rr = 0; occ = 0; drop = 0;
      forced_rst_done = 0;

      for (int cyc = 0; cyc < Cycles; cyc++) begin
         @(negedge clk_i);
         for (int i = 0; i < NumIn; i++) inp_data_i[i] = $urandom;
         if (cyc >= 3 && cyc < 14) begin
            // Fairness window: everything requesting, sink always ready.
            inp_valid_i = '1;
            oup_ready_i = 1'b1;
            flush_req_i = 1'b0;
         end else begin
            inp_valid_i = 4'($urandom);
            oup_ready_i = ($urandom_range(0, 9) < 7);
            flush_req_i = ($urandom_range(0, 11) == 0);
         end
         rst_i = (cyc < 3) || (phase == 2 && (!forced_rst_done || $urandom_range(0, 7) == 0))
                 || ($urandom_range(0, 499) == 0);
         if (rst_i && phase == 2) forced_rst_done = 1;
         #1;

         // Expected combinational outputs for this cycle.
         exp_ready = '0;
         found     = 0;
         g         = 0;
         if (!rst_i && phase == 0 && !flush_req_i && occ < 2) begin
            for (int k = 0; k < NumIn; k++) begin
               if (!found && inp_valid_i[(rr + k) % NumIn]) begin
                  g     = (rr + k) % NumIn;
                  found = 1;
               end
            end
            if (found) exp_ready[g] = 1'b1;
         end
         exp_valid = !rst_i && occ > 0 && phase != 2;
         in_hs     = found;
         out_hs    = exp_valid && oup_ready_i;

         check("inp_ready", 64'(inp_ready_o), 64'(exp_ready));
         check("oup_valid", 64'(oup_valid_o), 64'(exp_valid));
         check("flush_busy", 64'(flush_busy_o), 64'(!rst_i && phase != 0));
         check("flush_done", 64'(flush_done_o), 64'(!rst_i && phase == 3));
         if (!rst_i) check("flush_drop", 64'(flush_drop_o), 64'(drop));

         // Advance the model to the state after this rising edge.
         if (rst_i) begin
            phase = 0; rr = 0; occ = 0; drop = 0;
            exp_q.delete();
         end else begin
            if (in_hs) begin
               exp_q.push_back({2'(g), inp_data_i[g]});
               rr = (g + 1) % NumIn;
            end
            occ = occ + (in_hs ? 1 : 0) - (out_hs ? 1 : 0);
            case (phase)
               0: if (flush_req_i) phase = 1;
               1: phase = 2;
               2: begin
                  drop  = occ;
                  occ   = 0;
                  rr    = 0;
                  exp_q.delete();
                  phase = 3;
               end
               default: phase = 0;
            endcase
         end
      end

      @(negedge clk_i);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
